// File: rtl/store_buffer.sv
// In-order store buffer fed by the store-AGU pipe.
// Each accepted store is reported to the ROB one cycle later. Non-trapping
// stores are then held until the ROB commits them, and committed stores are
// drained to the data cache one at a time over a req/ack handshake.
// Three pointers (head, cmt, tail) split the ring into a committed region
// [head, cmt) and a speculative region [cmt, tail). Each pointer carries one
// extra wrap bit so that a full ring and an empty ring can be told apart.
module store_buffer #(
  parameter int         DEPTH    = 8,
  parameter logic [6:0] ALE_CODE = 7'h09
) (
  input  logic        Clk,
  input  logic        Rest,
  input  logic        SBFlash,
  input  logic        SBInAble,
  input  logic [7:0]  SBInMicOp,
  input  logic [31:0] SBInWDate,
  input  logic [1:0]  SBInMAT,
  input  logic [31:0] SBInPAddr,
  input  logic        SBInTrap,
  input  logic [6:0]  SBInTrapCode,
  input  logic        SBInWbAble,
  input  logic [6:0]  SBInWbAddr,
  input  logic [5:0]  SBInRobPtr,
  output logic        SBFull,
  output logic        SBDoneAble,
  output logic [5:0]  SBDoneRobPtr,
  output logic        SBDoneTrap,
  output logic [6:0]  SBDoneTrapCode,
  output logic        SBDoneWbAble,
  output logic [6:0]  SBDoneWbAddr,
  input  logic        CommitAble,
  input  logic [5:0]  CommitRobPtr,
  output logic        DcReq,
  output logic [31:0] DcAddr,
  output logic [31:0] DcDate,
  output logic [3:0]  DcMask,
  output logic        DcUncache,
  input  logic        DcAck
);

  localparam int IW = $clog2(DEPTH);

  typedef logic [IW:0] ptr_t;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_REQ  = 1'b1
  } drain_state_t;

  // Ring pointers: oldest entry, first uncommitted entry, next free slot.
  ptr_t head;
  ptr_t cmt;
  ptr_t tail;
  ptr_t cmt_next;
  ptr_t count;

  drain_state_t drain_state;

  // Entry storage. The address is kept word-aligned because byte placement
  // is already encoded in the mask and the lane-replicated data.
  logic [5:0]  ent_rob  [DEPTH];
  logic [29:0] ent_word [DEPTH];
  logic [31:0] ent_data [DEPTH];
  logic [3:0]  ent_mask [DEPTH];
  logic        ent_unc  [DEPTH];

  logic [IW-1:0] head_idx;
  logic [IW-1:0] cmt_idx;
  logic [IW-1:0] tail_idx;

  logic [1:0]  in_size;
  logic        misaligned;
  logic        in_trap;
  logic [6:0]  in_code;
  logic [3:0]  in_mask;
  logic [31:0] in_data;
  logic        accept;
  logic        alloc;
  logic        commit_hit;

  // Only the size field of the micro-op matters to this block.
  logic unused_micop;
  assign unused_micop = &{1'b0, SBInMicOp[7:2]};

  assign head_idx = head[IW-1:0];
  assign cmt_idx  = cmt[IW-1:0];
  assign tail_idx = tail[IW-1:0];

  assign count  = tail - head;
  assign SBFull = (count == ptr_t'(DEPTH));

  assign accept = SBInAble & ~SBFull & ~SBFlash & ~Rest;
  assign alloc  = accept & ~in_trap;

  // Decode the incoming store: alignment trap, byte strobe and lane data.
  always_comb begin
    in_size    = SBInMicOp[1:0];
    misaligned = 1'b0;
    in_mask    = 4'b1111;
    in_data    = SBInWDate;
    case (in_size)
      2'b00: begin
        in_mask = 4'b0001 << SBInPAddr[1:0];
        in_data = {4{SBInWDate[7:0]}};
      end
      2'b01: begin
        misaligned = SBInPAddr[0];
        in_mask    = SBInPAddr[1] ? 4'b1100 : 4'b0011;
        in_data    = {2{SBInWDate[15:0]}};
      end
      default: begin
        misaligned = (SBInPAddr[1:0] != 2'b00);
        in_mask    = 4'b1111;
        in_data    = SBInWDate;
      end
    endcase
    in_trap = SBInTrap | misaligned;
    in_code = SBInTrap ? SBInTrapCode : ALE_CODE;
  end

  // A commit only advances cmt when it names the oldest uncommitted entry.
  always_comb begin
    commit_hit = CommitAble && (cmt != tail) && (ent_rob[cmt_idx] == CommitRobPtr);
    cmt_next   = commit_hit ? cmt + 1'b1 : cmt;
  end

  // Write non-trapping stores into the slot at tail, already formatted for the cache.
  always_ff @(posedge Clk) begin
    if (alloc) begin
      ent_rob[tail_idx]  <= SBInRobPtr;
      ent_word[tail_idx] <= SBInPAddr[31:2];
      ent_data[tail_idx] <= in_data;
      ent_mask[tail_idx] <= in_mask;
      ent_unc[tail_idx]  <= (SBInMAT == 2'b00);
    end
  end

  // Advance the commit and allocation pointers; a flush rewinds tail to the
  // post-commit cmt so that a same-cycle commit still survives.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      cmt  <= '0;
      tail <= '0;
    end else begin
      cmt <= cmt_next;
      if (SBFlash) begin
        tail <= cmt_next;
      end else if (alloc) begin
        tail <= tail + 1'b1;
      end
    end
  end

  // Register the completion report one cycle after every accepted store.
  always_ff @(posedge Clk) begin
    if (Rest || SBFlash) begin
      SBDoneAble     <= 1'b0;
      SBDoneRobPtr   <= '0;
      SBDoneTrap     <= 1'b0;
      SBDoneTrapCode <= '0;
      SBDoneWbAble   <= 1'b0;
      SBDoneWbAddr   <= '0;
    end else begin
      SBDoneAble     <= accept;
      SBDoneRobPtr   <= accept ? SBInRobPtr : 6'd0;
      SBDoneTrap     <= accept & in_trap;
      SBDoneTrapCode <= (accept && in_trap) ? in_code : 7'd0;
      SBDoneWbAble   <= accept & SBInWbAble;
      SBDoneWbAddr   <= accept ? SBInWbAddr : 7'd0;
    end
  end

  // Drain committed entries to the cache one at a time, leaving a one-cycle
  // gap between requests; the request fields stay frozen until the ack.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      drain_state <= DRAIN_IDLE;
      head        <= '0;
      DcReq       <= 1'b0;
      DcAddr      <= '0;
      DcDate      <= '0;
      DcMask      <= '0;
      DcUncache   <= 1'b0;
    end else begin
      case (drain_state)
        DRAIN_IDLE: begin
          DcReq <= 1'b0;
          if (head != cmt) begin
            drain_state <= DRAIN_REQ;
            DcReq       <= 1'b1;
            DcAddr      <= {ent_word[head_idx], 2'b00};
            DcDate      <= ent_data[head_idx];
            DcMask      <= ent_mask[head_idx];
            DcUncache   <= ent_unc[head_idx];
          end
        end
        DRAIN_REQ: begin
          if (DcAck) begin
            drain_state <= DRAIN_IDLE;
            DcReq       <= 1'b0;
            head        <= head + 1'b1;
          end
        end
        default: begin
          drain_state <= DRAIN_IDLE;
          DcReq       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a table of single-store vectors with
// hand-computed completion and cache-request values, followed by hand-written
// sequences for full, back-pressure, flush, reset-mid-drain and pointer wrap.
module tb_store_buffer;

  logic        Clk = 1'b0;
  logic        Rest;
  logic        SBFlash;
  logic        SBInAble;
  logic [7:0]  SBInMicOp;
  logic [31:0] SBInWDate;
  logic [1:0]  SBInMAT;
  logic [31:0] SBInPAddr;
  logic        SBInTrap;
  logic [6:0]  SBInTrapCode;
  logic        SBInWbAble;
  logic [6:0]  SBInWbAddr;
  logic [5:0]  SBInRobPtr;
  logic        SBFull;
  logic        SBDoneAble;
  logic [5:0]  SBDoneRobPtr;
  logic        SBDoneTrap;
  logic [6:0]  SBDoneTrapCode;
  logic        SBDoneWbAble;
  logic [6:0]  SBDoneWbAddr;
  logic        CommitAble;
  logic [5:0]  CommitRobPtr;
  logic        DcReq;
  logic [31:0] DcAddr;
  logic [31:0] DcDate;
  logic [3:0]  DcMask;
  logic        DcUncache;
  logic        DcAck;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] paddr;
    logic [31:0] wdate;
    logic [1:0]  mat;
    logic        trap;
    logic [6:0]  tcode;
    logic [5:0]  rob;
    logic        exp_trap;
    logic [6:0]  exp_code;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
    logic        exp_unc;
  } vec_t;

  vec_t vecs [10];

  store_buffer #(.DEPTH(8), .ALE_CODE(7'h09)) dut (
    .Clk(Clk), .Rest(Rest), .SBFlash(SBFlash), .SBInAble(SBInAble),
    .SBInMicOp(SBInMicOp), .SBInWDate(SBInWDate), .SBInMAT(SBInMAT),
    .SBInPAddr(SBInPAddr), .SBInTrap(SBInTrap), .SBInTrapCode(SBInTrapCode),
    .SBInWbAble(SBInWbAble), .SBInWbAddr(SBInWbAddr), .SBInRobPtr(SBInRobPtr),
    .SBFull(SBFull), .SBDoneAble(SBDoneAble), .SBDoneRobPtr(SBDoneRobPtr),
    .SBDoneTrap(SBDoneTrap), .SBDoneTrapCode(SBDoneTrapCode),
    .SBDoneWbAble(SBDoneWbAble), .SBDoneWbAddr(SBDoneWbAddr),
    .CommitAble(CommitAble), .CommitRobPtr(CommitRobPtr),
    .DcReq(DcReq), .DcAddr(DcAddr), .DcDate(DcDate), .DcMask(DcMask),
    .DcUncache(DcUncache), .DcAck(DcAck)
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  // Hard stop in case a sequence gets stuck.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic reset_dut();
    Rest = 1'b1;
    tick();
    tick();
    Rest = 1'b0;
  endtask

  task automatic set_store(input logic [1:0] size, input logic [31:0] paddr, input logic [31:0] wdate,
                           input logic [1:0] mat, input logic trap, input logic [6:0] tcode,
                           input logic [5:0] rob);
    SBInAble     = 1'b1;
    SBInMicOp    = {6'b0, size};
    SBInPAddr    = paddr;
    SBInWDate    = wdate;
    SBInMAT      = mat;
    SBInTrap     = trap;
    SBInTrapCode = tcode;
    SBInRobPtr   = rob;
    SBInWbAble   = rob[0];
    SBInWbAddr   = {1'b0, rob} + 7'd10;
  endtask

  task automatic apply_stimulus(input logic [1:0] size, input logic [31:0] paddr, input logic [31:0] wdate,
                                input logic [1:0] mat, input logic trap, input logic [6:0] tcode,
                                input logic [5:0] rob);
    set_store(size, paddr, wdate, mat, trap, tcode, rob);
    tick();
    SBInAble = 1'b0;
  endtask

  task automatic commit(input logic [5:0] rob);
    CommitAble   = 1'b1;
    CommitRobPtr = rob;
    tick();
    CommitAble   = 1'b0;
  endtask

  task automatic drain_one(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input logic unc);
    int n = 0;
    while (!DcReq && n < 20) begin
      tick();
      n++;
    end
    check_output({name, " req"}, {31'b0, DcReq}, 32'd1);
    if (DcReq) begin
      check_output({name, " addr"}, DcAddr, addr);
      check_output({name, " data"}, DcDate, data);
      check_output({name, " mask"}, {28'b0, DcMask}, {28'b0, mask});
      check_output({name, " uncache"}, {31'b0, DcUncache}, {31'b0, unc});
      DcAck = 1'b1;
      tick();
      DcAck = 1'b0;
      check_output({name, " req drop"}, {31'b0, DcReq}, 32'd0);
    end
  endtask

  task automatic no_req_window(input string name, input int cycles);
    logic seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      seen |= DcReq;
    end
    check_output(name, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    Rest = 1'b1; SBFlash = 1'b0; SBInAble = 1'b0; SBInMicOp = '0; SBInWDate = '0;
    SBInMAT = '0; SBInPAddr = '0; SBInTrap = 1'b0; SBInTrapCode = '0; SBInWbAble = 1'b0;
    SBInWbAddr = '0; SBInRobPtr = '0; CommitAble = 1'b0; CommitRobPtr = '0; DcAck = 1'b0;

    //             size   paddr          wdate          mat    trap  tcode  rob   etrap ecode  eaddr          edata          emask    eunc
    vecs[0] = '{2'b10, 32'h1000_0004, 32'hDEAD_BEEF, 2'b01, 1'b0, 7'h00, 6'd5,  1'b0, 7'h00, 32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, 1'b0};
    vecs[1] = '{2'b00, 32'h1000_0003, 32'h0000_00AB, 2'b00, 1'b0, 7'h00, 6'd6,  1'b0, 7'h00, 32'h1000_0000, 32'hABAB_ABAB, 4'b1000, 1'b1};
    vecs[2] = '{2'b01, 32'h1000_0002, 32'h0000_1234, 2'b01, 1'b0, 7'h00, 6'd7,  1'b0, 7'h00, 32'h1000_0000, 32'h1234_1234, 4'b1100, 1'b0};
    vecs[3] = '{2'b01, 32'h1000_0001, 32'h0000_5555, 2'b01, 1'b0, 7'h00, 6'd8,  1'b1, 7'h09, 32'h0,          32'h0,          4'b0000, 1'b0};
    vecs[4] = '{2'b10, 32'h1000_0006, 32'h1111_2222, 2'b01, 1'b0, 7'h00, 6'd9,  1'b1, 7'h09, 32'h0,          32'h0,          4'b0000, 1'b0};
    vecs[5] = '{2'b00, 32'h2000_0001, 32'hFFFF_FF5A, 2'b10, 1'b0, 7'h00, 6'd10, 1'b0, 7'h00, 32'h2000_0000, 32'h5A5A_5A5A, 4'b0010, 1'b0};
    vecs[6] = '{2'b01, 32'h2000_0000, 32'hFFFF_BEEF, 2'b11, 1'b0, 7'h00, 6'd11, 1'b0, 7'h00, 32'h2000_0000, 32'hBEEF_BEEF, 4'b0011, 1'b0};
    vecs[7] = '{2'b10, 32'h0000_0003, 32'h0000_0001, 2'b01, 1'b1, 7'h1F, 6'd12, 1'b1, 7'h1F, 32'h0,          32'h0,          4'b0000, 1'b0};
    vecs[8] = '{2'b11, 32'h3000_0008, 32'h0123_4567, 2'b00, 1'b0, 7'h00, 6'd13, 1'b0, 7'h00, 32'h3000_0008, 32'h0123_4567, 4'b1111, 1'b1};
    vecs[9] = '{2'b00, 32'h3000_0010, 32'h0000_0011, 2'b01, 1'b0, 7'h00, 6'd14, 1'b0, 7'h00, 32'h3000_0010, 32'h1111_1111, 4'b0001, 1'b0};

    tick();
    tick();
    Rest = 1'b0;
    check_output("reset DcReq", {31'b0, DcReq}, 32'd0);
    check_output("reset SBFull", {31'b0, SBFull}, 32'd0);
    check_output("reset SBDoneAble", {31'b0, SBDoneAble}, 32'd0);
    check_output("reset DcAddr", DcAddr, 32'd0);

    // Table-driven single stores.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].size, vecs[i].paddr, vecs[i].wdate, vecs[i].mat,
                     vecs[i].trap, vecs[i].tcode, vecs[i].rob);
      check_output($sformatf("v%0d done", i), {31'b0, SBDoneAble}, 32'd1);
      check_output($sformatf("v%0d done rob", i), {26'b0, SBDoneRobPtr}, {26'b0, vecs[i].rob});
      check_output($sformatf("v%0d done trap", i), {31'b0, SBDoneTrap}, {31'b0, vecs[i].exp_trap});
      check_output($sformatf("v%0d done code", i), {25'b0, SBDoneTrapCode}, {25'b0, vecs[i].exp_code});
      check_output($sformatf("v%0d wb able", i), {31'b0, SBDoneWbAble}, {31'b0, vecs[i].rob[0]});
      check_output($sformatf("v%0d wb addr", i), {25'b0, SBDoneWbAddr}, {25'b0, ({1'b0, vecs[i].rob} + 7'd10)});
      if (vecs[i].exp_trap) begin
        no_req_window($sformatf("v%0d trap no req", i), 5);
        check_output($sformatf("v%0d trap not full", i), {31'b0, SBFull}, 32'd0);
      end else begin
        commit(vecs[i].rob);
        check_output($sformatf("v%0d req latency", i), {31'b0, DcReq}, 32'd0);
        check_output($sformatf("v%0d done idle", i), {31'b0, SBDoneAble}, 32'd0);
        drain_one($sformatf("v%0d", i), vecs[i].exp_addr, vecs[i].exp_data,
                  vecs[i].exp_mask, vecs[i].exp_unc);
      end
    end

    // Fill to full; the held 9th store is accepted exactly once after a drain.
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(2'b10, 32'h5000_0000 + 32'(i * 4), 32'h0000_00A0 + 32'(i), 2'b01, 1'b0, 7'h00, 6'(i));
    end
    check_output("fill full", {31'b0, SBFull}, 32'd1);
    begin
      logic seen = 1'b0;
      int   dones = 0;
      set_store(2'b10, 32'h5000_0020, 32'h0000_00A8, 2'b01, 1'b0, 7'h00, 6'd8);
      for (int k = 0; k < 3; k++) begin
        tick();
        seen |= SBDoneAble;
      end
      check_output("full blocks input", {31'b0, seen}, 32'd0);
      commit(6'd0);
      drain_one("full drain0", 32'h5000_0000, 32'h0000_00A0, 4'b1111, 1'b0);
      for (int k = 0; k < 5; k++) begin
        tick();
        if (SBDoneAble) begin
          dones++;
          check_output("held store rob", {26'b0, SBDoneRobPtr}, 32'd8);
          SBInAble = 1'b0;
        end
      end
      SBInAble = 1'b0;
      check_output("held store once", 32'(dones), 32'd1);
      check_output("full again", {31'b0, SBFull}, 32'd1);
    end

    // Back-pressure: request must stay stable while ack is withheld.
    reset_dut();
    apply_stimulus(2'b10, 32'h6000_0000, 32'hCAFE_0001, 2'b01, 1'b0, 7'h00, 6'd10);
    apply_stimulus(2'b10, 32'h6000_0004, 32'hCAFE_0002, 2'b01, 1'b0, 7'h00, 6'd11);
    commit(6'd10);
    commit(6'd11);
    begin
      int n = 0;
      logic stable = 1'b1;
      while (!DcReq && n < 20) begin
        tick();
        n++;
      end
      check_output("bp req", {31'b0, DcReq}, 32'd1);
      for (int k = 0; k < 5; k++) begin
        tick();
        if (!DcReq || DcAddr !== 32'h6000_0000 || DcDate !== 32'hCAFE_0001 || DcMask !== 4'b1111)
          stable = 1'b0;
      end
      check_output("bp stable", {31'b0, stable}, 32'd1);
      DcAck = 1'b1;
      tick();
      DcAck = 1'b0;
      check_output("bp pop", {31'b0, DcReq}, 32'd0);
      drain_one("bp second", 32'h6000_0004, 32'hCAFE_0002, 4'b1111, 1'b0);
      no_req_window("bp only two", 4);
    end

    // Flush in the same cycle as the second commit.
    reset_dut();
    apply_stimulus(2'b10, 32'h7000_0000, 32'h0000_0001, 2'b01, 1'b0, 7'h00, 6'd1);
    apply_stimulus(2'b10, 32'h7000_0004, 32'h0000_0002, 2'b01, 1'b0, 7'h00, 6'd2);
    apply_stimulus(2'b10, 32'h7000_0008, 32'h0000_0003, 2'b01, 1'b0, 7'h00, 6'd3);
    commit(6'd1);
    set_store(2'b10, 32'h7000_000C, 32'h0000_0004, 2'b01, 1'b0, 7'h00, 6'd4);
    SBFlash = 1'b1;
    commit(6'd2);
    SBFlash  = 1'b0;
    SBInAble = 1'b0;
    check_output("flush drops input", {31'b0, SBDoneAble}, 32'd0);
    drain_one("flush e1", 32'h7000_0000, 32'h0000_0001, 4'b1111, 1'b0);
    drain_one("flush e2", 32'h7000_0004, 32'h0000_0002, 4'b1111, 1'b0);
    commit(6'd3);
    commit(6'd4);
    no_req_window("flush discarded", 6);
    check_output("flush empty", {31'b0, SBFull}, 32'd0);

    // Reset while a request is outstanding, then normal operation resumes.
    reset_dut();
    apply_stimulus(2'b10, 32'h7000_0010, 32'h0000_0020, 2'b00, 1'b0, 7'h00, 6'd20);
    commit(6'd20);
    tick();
    check_output("pre-reset req", {31'b0, DcReq}, 32'd1);
    Rest = 1'b1;
    tick();
    Rest = 1'b0;
    check_output("rst DcReq", {31'b0, DcReq}, 32'd0);
    check_output("rst DcAddr", DcAddr, 32'd0);
    check_output("rst DcDate", DcDate, 32'd0);
    check_output("rst DcMask", {28'b0, DcMask}, 32'd0);
    check_output("rst DcUncache", {31'b0, DcUncache}, 32'd0);
    check_output("rst SBFull", {31'b0, SBFull}, 32'd0);
    check_output("rst SBDoneAble", {31'b0, SBDoneAble}, 32'd0);
    no_req_window("rst abandoned", 3);
    apply_stimulus(2'b00, 32'h7000_0015, 32'h0000_00C3, 2'b01, 1'b0, 7'h00, 6'd21);
    check_output("post-rst done", {31'b0, SBDoneAble}, 32'd1);
    commit(6'd21);
    drain_one("post-rst", 32'h7000_0014, 32'hC3C3_C3C3, 4'b0010, 1'b0);

    // Twenty stores through an 8-entry ring to exercise pointer wrap.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(2'b10, 32'h4000_0000 + 32'(i * 4), 32'h0101_0101 * 32'(i + 1), 2'b01, 1'b0, 7'h00, 6'(30 + i));
      commit(6'(30 + i));
      drain_one($sformatf("wrap%0d", i), 32'h4000_0000 + 32'(i * 4), 32'h0101_0101 * 32'(i + 1), 4'b1111, 1'b0);
    end
    check_output("wrap empty", {31'b0, SBFull}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
